// File: rtl/pending_priority_encoder.sv
// Registered pending-request priority encoder with fixed or round-robin selection.
// Define PENC_OVERFLOW_EN to enable the sticky lost-request overflow flag.
module pending_priority_encoder #(
    parameter int N     = 16,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_i,
    input  logic             rr_mode,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic [N-1:0]     pending,
    output logic             any_pending,
    input  logic             ovf_clr,
    output logic             overflow
);

    logic [N-1:0]     pending_q, pending_d;
    logic             out_valid_q, out_valid_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             overflow_q, overflow_d;

    logic [IDX_W-1:0] fixed_idx;
    logic [IDX_W-1:0] rr_lower_idx, rr_upper_idx, rr_idx;
    logic             rr_lower_found;
    logic [IDX_W-1:0] sel_idx;
    logic             out_free;
    logic             load;
    logic [N-1:0]     take;

    always_comb begin
        fixed_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (pending_q[i]) begin
                fixed_idx = IDX_W'(i);
            end
        end
    end

    // Round-robin walks down from ptr-1 and wraps: first the channels below ptr,
    // otherwise the highest pending channel at or above ptr.
    always_comb begin
        rr_lower_idx   = '0;
        rr_lower_found = 1'b0;
        rr_upper_idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (pending_q[i]) begin
                if (IDX_W'(i) < ptr_q) begin
                    rr_lower_idx   = IDX_W'(i);
                    rr_lower_found = 1'b1;
                end else begin
                    rr_upper_idx = IDX_W'(i);
                end
            end
        end
        rr_idx = rr_lower_found ? rr_lower_idx : rr_upper_idx;
    end

    always_comb begin
        sel_idx     = rr_mode ? rr_idx : fixed_idx;
        out_free    = !out_valid_q || out_ready;
        load        = out_free && (pending_q != '0);
        take        = '0;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        ptr_d       = ptr_q;
        if (load) begin
            take[sel_idx] = 1'b1;
            out_idx_d     = sel_idx;
            ptr_d         = sel_idx;
        end
        if (out_free) begin
            out_valid_d = load;
        end
        // A fresh request on the channel being taken keeps it pending.
        pending_d = (pending_q & ~take) | req_i;
    end

`ifdef PENC_OVERFLOW_EN
    always_comb begin
        overflow_d = overflow_q;
        if (ovf_clr) begin
            overflow_d = 1'b0;
        end
        if ((req_i & pending_q & ~take) != '0) begin
            overflow_d = 1'b1;
        end
    end
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;

    always_comb begin
        overflow_d = 1'b0;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            ptr_q       <= '0;
            overflow_q  <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            ptr_q       <= ptr_d;
            overflow_q  <= overflow_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_idx     = out_idx_q;
    assign pending     = pending_q;
    assign any_pending = |pending_q;
    assign overflow    = overflow_q;

endmodule
